// File: rtl/hazard_stall_ctrl.sv
// Hazard controller: load-use detection, multi-cycle multiply stall sequencing,
// taken-branch squash, and a saturating stall-cycle counter for perf debug.
module hazard_stall_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_rs1_used,
  input  logic             if_id_rs2_used,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_mul_start,
  input  logic             ex_branch_taken,
  output logic             ctrl_sgnl_sel,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_hold,
  output logic             if_id_flush,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MUL_WAIT, MUL_LAST} state_t;

  // The first stall cycle happens in RUN; MUL_WAIT covers the remaining
  // MUL_LATENCY-2 stall cycles, so its countdown starts at MUL_LATENCY-3.
  localparam logic [3:0] WAIT_INIT  = 4'((MUL_LATENCY > 2) ? (MUL_LATENCY - 3) : 0);
  localparam logic       MUL_STALLS = (MUL_LATENCY > 1);
  localparam logic       USE_WAIT   = (MUL_LATENCY > 2);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mul_stall;
  logic       load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((if_id_rs1_used && (if_id_rs1 == id_ex_rd)) ||
                     (if_id_rs2_used && (if_id_rs2 == id_ex_rd)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mul_stall = 1'b0;
    case (state)
      RUN: begin
        if (ex_mul_start && MUL_STALLS) begin
          mul_stall = 1'b1;
          if (USE_WAIT) begin
            state_nxt = MUL_WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt = MUL_LAST;
          end
        end
      end
      MUL_WAIT: begin
        mul_stall = 1'b1;
        if (cnt == 4'd0) state_nxt = MUL_LAST;
        else             cnt_nxt   = cnt - 4'd1;
      end
      // Multiply's final EX cycle: the still-asserted start must not retrigger.
      MUL_LAST: state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    ctrl_sgnl_sel = 1'b1;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_hold    = 1'b0;
    if_id_flush   = 1'b0;
    mul_busy      = 1'b0;
    if (!reset_n) begin
      ctrl_sgnl_sel = 1'b0;
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
    end else if (mul_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_hold  = 1'b1;
      mul_busy    = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is squashed, so a coincident load-use is moot.
      ctrl_sgnl_sel = 1'b0;
      if_id_flush   = 1'b1;
    end else if (load_use) begin
      ctrl_sgnl_sel = 1'b0;
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      stall_cycles <= '0;
    else if (!pc_write) stall_cycles <= sat_inc(stall_cycles);
  end

endmodule
